// File: rtl/alu_cmd_ctrl_if.sv
// Byte-stream and ALU-side signal bundle for alu_cmd_ctrl.
// master = the sequencer, slave = the UART/ALU environment around it.
interface alu_cmd_ctrl_if #(
  parameter int BUS_SIZE    = 8,
  parameter int OPCODE_SIZE = 6
) ();
  logic                   i_rx_valid;
  logic [BUS_SIZE-1:0]    i_rx_data;
  logic [BUS_SIZE-1:0]    o_alu_a;
  logic [BUS_SIZE-1:0]    o_alu_b;
  logic [OPCODE_SIZE-1:0] o_alu_op;
  logic [BUS_SIZE-1:0]    i_alu_result;
  logic                   i_alu_carry;
  logic                   o_tx_start;
  logic [BUS_SIZE-1:0]    o_tx_data;
  logic                   i_tx_done;
  logic                   o_busy;
  logic                   o_op_err;
  logic                   o_overrun;

  modport master (
    input  i_rx_valid, i_rx_data, i_alu_result, i_alu_carry, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
           o_busy, o_op_err, o_overrun
  );

  modport slave (
    output i_rx_valid, i_rx_data, i_alu_result, i_alu_carry, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
           o_busy, o_op_err, o_overrun
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Collects A, B, opcode bytes, drives the ALU, waits ALU_LAT cycles and sends the result.
// Define ALU_CTRL_CARRY_TX_EN to also transmit a carry byte after each result.
module alu_cmd_ctrl #(
  parameter int BUS_SIZE    = 8,
  parameter int OPCODE_SIZE = 6,
  parameter int ALU_LAT     = 2
) (
  input logic           i_clock,
  input logic           i_reset_n,
  alu_cmd_ctrl_if.master bus
);
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(6'b100000);
  localparam logic [OPCODE_SIZE-1:0] LEGAL_OPS [8] = '{
    OPCODE_SIZE'(6'b100000), OPCODE_SIZE'(6'b100010), OPCODE_SIZE'(6'b100100),
    OPCODE_SIZE'(6'b100101), OPCODE_SIZE'(6'b100110), OPCODE_SIZE'(6'b100111),
    OPCODE_SIZE'(6'b000010), OPCODE_SIZE'(6'b000011)
  };

  typedef enum logic [2:0] {
    GET_A, GET_B, GET_OP, EXEC, SEND_RES, WAIT_RES
`ifdef ALU_CTRL_CARRY_TX_EN
    , SEND_CRY, WAIT_CRY
`endif
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BUS_SIZE-1:0]    a_reg, a_next;
  logic [BUS_SIZE-1:0]    b_reg, b_next;
  logic [OPCODE_SIZE-1:0] op_reg, op_next;
  logic [BUS_SIZE-1:0]    tx_data_reg, tx_data_next;
  logic                   tx_start_reg, tx_start_next;
  logic                   busy_reg, busy_next;
  logic                   op_err_reg, op_err_next;
  logic                   overrun_reg, overrun_next;
  logic [7:0]             op_hit;
  logic                   op_legal;

  // Opcode byte is legal only with clear upper bits and a low field from the table.
  for (genvar gi = 0; gi < 8; gi++) begin : g_op_match
    assign op_hit[gi] = (bus.i_rx_data[OPCODE_SIZE-1:0] == LEGAL_OPS[gi]);
  end
  assign op_legal = (bus.i_rx_data[BUS_SIZE-1:OPCODE_SIZE] == '0) && (|op_hit);

`ifdef ALU_CTRL_CARRY_TX_EN
  logic carry_reg, carry_next;
`else
  logic unused_carry;
  assign unused_carry = bus.i_alu_carry;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= GET_A;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= OP_ADD;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      op_err_reg   <= 1'b0;
      overrun_reg  <= 1'b0;
`ifdef ALU_CTRL_CARRY_TX_EN
      carry_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      op_reg       <= op_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      busy_reg     <= busy_next;
      op_err_reg   <= op_err_next;
      overrun_reg  <= overrun_next;
`ifdef ALU_CTRL_CARRY_TX_EN
      carry_reg    <= carry_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    op_next       = op_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    op_err_next   = op_err_reg;
    overrun_next  = overrun_reg;
`ifdef ALU_CTRL_CARRY_TX_EN
    carry_next    = carry_reg;
`endif
    case (state_reg)
      GET_A: if (bus.i_rx_valid) begin
        a_next     = bus.i_rx_data;
        state_next = GET_B;
      end
      GET_B: if (bus.i_rx_valid) begin
        b_next     = bus.i_rx_data;
        state_next = GET_OP;
      end
      GET_OP: if (bus.i_rx_valid) begin
        if (op_legal) begin
          op_next    = bus.i_rx_data[OPCODE_SIZE-1:0];
          cnt_next   = CNT_W'(ALU_LAT - 1);
          state_next = EXEC;
        end else begin
          op_err_next = 1'b1;
          state_next  = GET_A;
        end
      end
      EXEC: begin
        if (cnt_reg == '0) begin
          tx_data_next  = bus.i_alu_result;
          tx_start_next = 1'b1;
`ifdef ALU_CTRL_CARRY_TX_EN
          carry_next    = bus.i_alu_carry;
`endif
          state_next    = SEND_RES;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      SEND_RES: state_next = WAIT_RES;
      WAIT_RES: if (bus.i_tx_done) begin
`ifdef ALU_CTRL_CARRY_TX_EN
        // Carry byte is loaded on entry so data and start appear together.
        tx_data_next  = {{(BUS_SIZE-1){1'b0}}, carry_reg};
        tx_start_next = 1'b1;
        state_next    = SEND_CRY;
`else
        state_next = GET_A;
`endif
      end
`ifdef ALU_CTRL_CARRY_TX_EN
      SEND_CRY: state_next = WAIT_CRY;
      WAIT_CRY: if (bus.i_tx_done) state_next = GET_A;
`endif
      default: state_next = GET_A;
    endcase
    if (bus.i_rx_valid && !(state_reg inside {GET_A, GET_B, GET_OP}))
      overrun_next = 1'b1;
  end

  assign busy_next = (state_next != GET_A);

  assign bus.o_alu_a    = a_reg;
  assign bus.o_alu_b    = b_reg;
  assign bus.o_alu_op   = op_reg;
  assign bus.o_tx_data  = tx_data_reg;
  assign bus.o_tx_start = tx_start_reg;
  assign bus.o_busy     = busy_reg;
  assign bus.o_op_err   = op_err_reg;
  assign bus.o_overrun  = overrun_reg;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed plus randomized frames for alu_cmd_ctrl against a frame-level reference model.
module tb_alu_cmd_ctrl;
  localparam int BUS_SIZE = 8;
  localparam int OPCODE_SIZE = 6;
  localparam int ALU_LAT = 2;

  logic i_clock = 1'b0;
  logic i_reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [5:0] last_op = 6'b100000;
  logic op_err_exp = 1'b0;
  logic overrun_exp = 1'b0;
  logic [8:0] alu_pipe;
  logic [5:0] legal_tab [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b000010, 6'b000011};

  alu_cmd_ctrl_if #(.BUS_SIZE(BUS_SIZE), .OPCODE_SIZE(OPCODE_SIZE)) bus ();

  alu_cmd_ctrl #(.BUS_SIZE(BUS_SIZE), .OPCODE_SIZE(OPCODE_SIZE), .ALU_LAT(ALU_LAT)) dut (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'b100000: return {1'b0, a} + {1'b0, b};
      6'b100010: return {1'b0, a} - {1'b0, b};
      6'b100100: return {1'b0, a & b};
      6'b100101: return {1'b0, a | b};
      6'b100110: return {1'b0, a ^ b};
      6'b100111: return {1'b0, ~(a | b)};
      6'b000010: return {1'b0, a >> b};
      6'b000011: return {1'b0, 8'($signed(a) >>> b)};
      default:   return 9'h000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [7:0] v);
    return (v[7:6] == 2'b00) && (v[5:0] inside {6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b100110, 6'b100111, 6'b000010, 6'b000011});
  endfunction

  // ALU stand-in: one register stage, so the result is valid ALU_LAT-1 edges after inputs settle.
  always @(posedge i_clock) alu_pipe <= alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
  assign bus.i_alu_result = alu_pipe[7:0];
  assign bus.i_alu_carry  = alu_pipe[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = v;
    tick();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'($urandom);
  endtask

  task automatic pulse_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_a"}, bus.o_alu_a, 8'h00);
    chk({tag, "_alu_b"}, bus.o_alu_b, 8'h00);
    chk({tag, "_alu_op"}, bus.o_alu_op, 6'b100000);
    chk({tag, "_tx_data"}, bus.o_tx_data, 8'h00);
    chk({tag, "_tx_start"}, bus.o_tx_start, 1'b0);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_op_err"}, bus.o_op_err, 1'b0);
    chk({tag, "_overrun"}, bus.o_overrun, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input bit ovr_exec, input bit ovr_wait, input bit stray_done,
                           input int wait_cycles);
    logic [8:0] exp;
    send_byte(a);
    chk("busy_after_a", bus.o_busy, 1'b1);
    chk("alu_a", bus.o_alu_a, a);
    if (stray_done) begin
      pulse_done();
      chk("stray_done_busy", bus.o_busy, 1'b1);
      chk("stray_done_tx_start", bus.o_tx_start, 1'b0);
      chk("stray_done_alu_b_hold", bus.o_alu_b, dut.b_reg);
    end
    send_byte(b);
    chk("alu_b", bus.o_alu_b, b);
    send_byte(opb);
    if (!is_legal(opb)) begin
      op_err_exp = 1'b1;
      chk("op_err", bus.o_op_err, op_err_exp);
      chk("alu_op_kept", bus.o_alu_op, last_op);
      chk("busy_after_bad_op", bus.o_busy, 1'b0);
      for (int k = 0; k < ALU_LAT + 2; k++) begin
        chk("no_tx_after_bad_op", bus.o_tx_start, 1'b0);
        tick();
      end
      return;
    end
    last_op = opb[5:0];
    exp = alu_ref(a, b, opb[5:0]);
    chk("alu_op", bus.o_alu_op, last_op);
    chk("busy_exec", bus.o_busy, 1'b1);
    chk("tx_start_early", bus.o_tx_start, 1'b0);
    for (int k = 0; k < ALU_LAT - 1; k++) begin
      if (ovr_exec && k == 0) begin
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'hAA;
        overrun_exp    = 1'b1;
      end
      tick();
      bus.i_rx_valid = 1'b0;
      chk("tx_start_exec", bus.o_tx_start, 1'b0);
    end
    tick();
    chk("tx_start", bus.o_tx_start, 1'b1);
    chk("tx_result", bus.o_tx_data, exp[7:0]);
    chk("overrun", bus.o_overrun, overrun_exp);
    chk("alu_a_hold", bus.o_alu_a, a);
    chk("alu_b_hold", bus.o_alu_b, b);
    for (int k = 0; k < wait_cycles; k++) begin
      if (ovr_wait && k == wait_cycles - 1) begin
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'hAA;
        overrun_exp    = 1'b1;
      end
      tick();
      bus.i_rx_valid = 1'b0;
      chk("tx_start_pulse_width", bus.o_tx_start, 1'b0);
      chk("tx_result_stable", bus.o_tx_data, exp[7:0]);
    end
    pulse_done();
`ifdef ALU_CTRL_CARRY_TX_EN
    chk("tx_start_carry", bus.o_tx_start, 1'b1);
    chk("tx_carry", bus.o_tx_data, {7'b0, exp[8]});
    chk("busy_carry", bus.o_busy, 1'b1);
    tick();
    chk("tx_start_carry_width", bus.o_tx_start, 1'b0);
    pulse_done();
`endif
    chk("busy_idle", bus.o_busy, 1'b0);
    chk("tx_start_idle", bus.o_tx_start, 1'b0);
    chk("overrun_end", bus.o_overrun, overrun_exp);
    chk("op_err_end", bus.o_op_err, op_err_exp);
  endtask

  initial begin
    logic [7:0] ra, rb, rop;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_tx_done  = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    i_reset_n = 1'b1;
    tick();

    run_frame(8'h05, 8'h03, 8'h20, 1'b0, 1'b0, 1'b0, 1);
    run_frame(8'hFF, 8'h01, 8'h20, 1'b0, 1'b0, 1'b0, 2);
    run_frame(8'h00, 8'h01, 8'h22, 1'b0, 1'b0, 1'b0, 3);
    run_frame(8'h11, 8'h22, 8'h21, 1'b0, 1'b0, 1'b0, 1);
    run_frame(8'h33, 8'h44, 8'h60, 1'b0, 1'b0, 1'b0, 1);
    run_frame(8'h05, 8'h03, 8'h20, 1'b0, 1'b0, 1'b0, 1);
    run_frame(8'h12, 8'h34, 8'h24, 1'b1, 1'b1, 1'b0, 3);
    run_frame(8'h9C, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1, 2);

    // Reset while waiting for the transmitter after o_tx_start.
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'h26);
    tick();
    tick();
    chk("pre_reset_tx_start", bus.o_tx_start, 1'b1);
    tick();
    #2;
    i_reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    last_op = 6'b100000;
    op_err_exp = 1'b0;
    overrun_exp = 1'b0;
    tick();
    i_reset_n = 1'b1;
    pulse_done();
    chk("late_done_busy", bus.o_busy, 1'b0);
    chk("late_done_tx_start", bus.o_tx_start, 1'b0);
    run_frame(8'h0F, 8'hF0, 8'h25, 1'b0, 1'b0, 1'b0, 1);

    for (int f = 0; f < 40; f++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        rop = 8'($urandom);
        if (is_legal(rop)) rop = 8'hFF;
      end else begin
        rop = {2'b00, legal_tab[$urandom_range(0, 7)]};
      end
      run_frame(ra, rb, rop, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0, int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
